// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the push-button debouncer: FSM encodings and default sizing,
// kept here so the bench and the LED show top level agree on the same values.
package button_debouncer_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } deb_state_t;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 16;
  localparam int COUNT_WIDTH_DEFAULT     = 8;

endpackage

// File: rtl/button_debouncer_sync_2ff.sv
// Single-bit two-flop synchroniser for asynchronous pin inputs; clears to 0 on reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Debounces a raw push-button pin into a clean level, one-cycle press/release strobes
// and a wrapping count of accepted presses.
//
// state     | meaning
// IDLE_LOW  | accepted level 0, synchronised input agrees
// WAIT_HIGH | input went high, counting consecutive high samples
// IDLE_HIGH | accepted level 1, synchronised input agrees
// WAIT_LOW  | input went low, counting consecutive low samples
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int COUNT_WIDTH     = COUNT_WIDTH_DEFAULT
) (
  input  logic                   clock,
  input  logic                   resetN,
  input  logic                   pushButtonRaw,
  output logic                   pushButton,
  output logic                   pressPulse,
  output logic                   releasePulse,
  output logic [COUNT_WIDTH-1:0] pressCount
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic                   s2;
  deb_state_t             state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic                   level_nxt, press_nxt, release_nxt;
  logic [COUNT_WIDTH-1:0] count_nxt;

  sync_2ff u_sync (
    .clk   (clock),
    .rst_n (resetN),
    .d     (pushButtonRaw),
    .q     (s2)
  );

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state        <= IDLE_LOW;
      cnt          <= '0;
      pushButton   <= 1'b0;
      pressPulse   <= 1'b0;
      releasePulse <= 1'b0;
      pressCount   <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      pushButton   <= level_nxt;
      pressPulse   <= press_nxt;
      releasePulse <= release_nxt;
      pressCount   <= count_nxt;
    end
  end

  // A WAIT state needs DEBOUNCE_CYCLES agreeing samples; the entry sample counts as the first.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    level_nxt   = pushButton;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    count_nxt   = pressCount;
    case (state)
      IDLE_LOW: begin
        if (s2) begin
          state_nxt = WAIT_HIGH;
          cnt_nxt   = CW'(1);
        end else begin
          cnt_nxt = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s2) begin
          state_nxt = IDLE_LOW;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_HIGH;
          cnt_nxt   = '0;
          level_nxt = 1'b1;
          press_nxt = 1'b1;
          count_nxt = pressCount + COUNT_WIDTH'(1);
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      IDLE_HIGH: begin
        if (!s2) begin
          state_nxt = WAIT_LOW;
          cnt_nxt   = CW'(1);
        end else begin
          cnt_nxt = '0;
        end
      end
      WAIT_LOW: begin
        if (s2) begin
          state_nxt = IDLE_HIGH;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = IDLE_LOW;
          cnt_nxt     = '0;
          level_nxt   = 1'b0;
          release_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE_LOW;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: directed scenarios plus random bouncing,
// compared every cycle against a run-length model of the debounce rule.
module tb_button_debouncer;

  localparam int D  = 4;
  localparam int CW = 8;

  logic          clock;
  logic          resetN;
  logic          pushButtonRaw;
  logic          pushButton;
  logic          pressPulse;
  logic          releasePulse;
  logic [CW-1:0] pressCount;

  int checks = 0;
  int errors = 0;

  // model: raw delay line, accepted level, length of current disagreeing run
  logic          dq0, dq1;
  logic          m_level, m_press, m_rel;
  int            m_run;
  logic [CW-1:0] m_count;

  button_debouncer #(.DEBOUNCE_CYCLES(D), .COUNT_WIDTH(CW)) dut (
    .clock         (clock),
    .resetN        (resetN),
    .pushButtonRaw (pushButtonRaw),
    .pushButton    (pushButton),
    .pressPulse    (pressPulse),
    .releasePulse  (releasePulse),
    .pressCount    (pressCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    dq0 = 1'b0; dq1 = 1'b0;
    m_level = 1'b0; m_press = 1'b0; m_rel = 1'b0;
    m_run = 0; m_count = '0;
  endtask

  // A new level is accepted once the synchronised input has disagreed with the
  // accepted level for D consecutive edges; any agreeing sample restarts the run.
  task automatic model_edge();
    logic s2;
    s2 = dq1;
    dq1 = dq0;
    dq0 = pushButtonRaw;
    m_press = 1'b0;
    m_rel   = 1'b0;
    if (s2 != m_level) begin
      m_run++;
      if (m_run == D) begin
        m_level = s2;
        m_run   = 0;
        if (s2) begin
          m_press = 1'b1;
          m_count = m_count + 1'b1;
        end else begin
          m_rel = 1'b1;
        end
      end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic compare_all();
    chk("pushButton",   int'(pushButton),   int'(m_level));
    chk("pressPulse",   int'(pressPulse),   int'(m_press));
    chk("releasePulse", int'(releasePulse), int'(m_rel));
    chk("pressCount",   int'(pressCount),   int'(m_count));
  endtask

  task automatic step(input logic r);
    pushButtonRaw = r;
    @(posedge clock);
    #1;
    model_edge();
    compare_all();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pushButton"},   int'(pushButton),   0);
    chk({tag, "_pressPulse"},   int'(pressPulse),   0);
    chk({tag, "_releasePulse"}, int'(releasePulse), 0);
    chk({tag, "_pressCount"},   int'(pressCount),   0);
  endtask

  task automatic press_release();
    repeat (7) step(1'b1);
    repeat (7) step(1'b0);
  endtask

  initial begin
    logic hold;
    resetN = 1'b0;
    pushButtonRaw = 1'b0;
    model_reset();
    #1;
    check_zero("reset");
    repeat (3) @(posedge clock);
    #1;
    resetN = 1'b1;

    // bounce from low: never D agreeing samples
    step(1'b1); step(1'b1); step(1'b0); step(1'b1); step(1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0);
      chk("bounce_level", int'(pushButton), 0);
      chk("bounce_press", int'(pressPulse), 0);
    end
    chk("bounce_count", int'(pressCount), 0);

    // clean press: accepted on the 6th edge after the first high sample
    for (int i = 1; i <= 8; i++) begin
      step(1'b1);
      if (i == 5) chk("press_e5_level", int'(pushButton), 0);
      if (i == 6) begin
        chk("press_e6_level", int'(pushButton), 1);
        chk("press_e6_pulse", int'(pressPulse), 1);
        chk("press_e6_count", int'(pressCount), 1);
      end
      if (i == 7) chk("press_e7_pulse", int'(pressPulse), 0);
    end

    // clean release
    for (int i = 1; i <= 8; i++) begin
      step(1'b0);
      if (i == 5) chk("release_e5_level", int'(pushButton), 1);
      if (i == 6) begin
        chk("release_e6_level", int'(pushButton), 0);
        chk("release_e6_pulse", int'(releasePulse), 1);
        chk("release_e6_count", int'(pressCount), 1);
      end
      if (i == 7) chk("release_e7_pulse", int'(releasePulse), 0);
    end

    // wrap of the press counter, starting from a fresh reset
    resetN = 1'b0;
    model_reset();
    #1;
    check_zero("reset2");
    @(posedge clock);
    #1;
    resetN = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      repeat (7) step(1'b1);
      if (k == 255) chk("wrap_255", int'(pressCount), 255);
      if (k == 256) chk("wrap_256", int'(pressCount), 0);
      repeat (7) step(1'b0);
    end

    press_release();
    press_release();
    chk("pre_reset_count", int'(pressCount), 2);

    // reset while in WAIT_HIGH with count 2, raw held high through release
    repeat (4) step(1'b1);
    #2;
    resetN = 1'b0;
    model_reset();
    #1;
    check_zero("async_reset");
    repeat (2) @(posedge clock);
    #1;
    check_zero("held_reset");
    resetN = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step(1'b1);
      if (i == 6) begin
        chk("rst_press_pulse", int'(pressPulse), 1);
        chk("rst_press_count", int'(pressCount), 1);
      end
    end

    // toggling every cycle: level holds, no strobes
    hold = m_level;
    for (int i = 0; i < 40; i++) begin
      step(i[0]);
      chk("toggle_level", int'(pushButton), int'(hold));
      chk("toggle_pulses", int'(pressPulse | releasePulse), 0);
    end

    // random runs of varying length around the debounce threshold
    for (int s = 0; s < 400; s++) begin
      logic lvl;
      int   len;
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 2 * D + 2);
      repeat (len) step(lvl);
    end
    repeat (10) step(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
